// File: rtl/maxnet_vector_writer.sv
// Write-side front end for the MaxNet engine: packs serial activation words into 4-word vectors
// held in a DEPTH-slot queue. Optional feature: MAXNET_CLAMP_NEG_EN (clamp negative words to 0, adds neg_seen).
module maxnet_vector_writer #(
  parameter int WIDTH = 32,
  parameter int NUM_X = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         x0,
  output logic [WIDTH-1:0]         x1,
  output logic [WIDTH-1:0]         x2,
  output logic [WIDTH-1:0]         x3,
  output logic                     vec_valid,
  input  logic                     vec_ack,
`ifdef MAXNET_CLAMP_NEG_EN
  output logic                     neg_seen,
`endif
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [1:0]               word_idx
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  // Handshake: a word moves on a rising edge where in_valid && in_ready; in_ready depends on
  // registered state only, and a vector is popped on a rising edge where vec_ack && vec_valid.

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2,
    W3 = 2'd3
  } fill_state_t;

  fill_state_t state, state_nxt;

  logic [WIDTH-1:0] mem [DEPTH][NUM_X];
  logic [WIDTH-1:0] x_q [NUM_X];
  logic [WIDTH-1:0] x_nxt [NUM_X];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [OCC_W-1:0] occ_nxt;
  logic [WIDTH-1:0] wdata;
  logic             ready_en;
  logic             accept, store_word, complete, pop;

  assign in_ready   = ready_en && (occupancy < OCC_W'(DEPTH));
  assign vec_valid  = (occupancy != '0);
  assign accept     = in_valid && in_ready;
  assign store_word = accept && !flush;
  assign complete   = store_word && (state == W3);
  assign pop        = vec_ack && vec_valid;
  assign word_idx   = state;

`ifdef MAXNET_CLAMP_NEG_EN
  assign wdata = in_data[WIDTH-1] ? '0 : in_data;
`else
  assign wdata = in_data;
`endif

  // Filling-slot sequencer; word_idx is this state.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = W0;
    end else if (accept) begin
      case (state)
        W0:      state_nxt = W1;
        W1:      state_nxt = W2;
        W2:      state_nxt = W3;
        default: state_nxt = W0;
      endcase
    end
  end

  always_comb begin
    wr_ptr_nxt = complete ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    occ_nxt    = occupancy;
    case ({complete, pop})
      2'b10:   occ_nxt = occupancy + OCC_W'(1);
      2'b01:   occ_nxt = occupancy - OCC_W'(1);
      default: occ_nxt = occupancy;
    endcase
  end

  // The vector completing this edge has its last word still on in_data, so forward it.
  always_comb begin
    for (int i = 0; i < NUM_X; i++) begin
      x_nxt[i] = x_q[i];
      if (occ_nxt != '0) begin
        if (complete && (wr_ptr == rd_ptr_nxt) && (i == NUM_X - 1))
          x_nxt[i] = wdata;
        else
          x_nxt[i] = mem[rd_ptr_nxt][i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= W0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      ready_en  <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      occupancy <= occ_nxt;
      ready_en  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < DEPTH; s++)
        for (int i = 0; i < NUM_X; i++)
          mem[s][i] <= '0;
      for (int i = 0; i < NUM_X; i++)
        x_q[i] <= '0;
    end else begin
      if (store_word)
        mem[wr_ptr][state] <= wdata;
      for (int i = 0; i < NUM_X; i++)
        x_q[i] <= x_nxt[i];
    end
  end

`ifdef MAXNET_CLAMP_NEG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      neg_seen <= 1'b0;
    else if (accept && in_data[WIDTH-1])
      neg_seen <= 1'b1;
  end
`endif

  assign x0 = x_q[0];
  assign x1 = x_q[1];
  assign x2 = x_q[2];
  assign x3 = x_q[3];

endmodule
